regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/rr_arbiter2.sv | 25 ++
 rtl/regfile_write_arbiter.sv | 101 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
//==============================================================================
// Module : regfile_pkg
// Desc   : Shared widths and requester-index type for the regfile write arbiter.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package regfile_pkg;

    localparam int ADDR_WIDTH_DEF = 3;
    localparam int DATA_WIDTH_DEF = 8;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_idx_t;

endpackage : regfile_pkg

`default_nettype wire

// File: rtl/rr_arbiter2.sv
//==============================================================================
// Module : rr_arbiter2
// Desc   : Two-way round-robin pick; a contended pick goes to the requester
//          that was not granted last.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic [1:0] eligible_i,
    input  req_idx_t   lastGrant_i,
    output logic [1:0] pick_o
);

    always_comb begin
        pick_o    = 2'b00;
        pick_o[0] = eligible_i[0] & (~eligible_i[1] | (lastGrant_i == REQ1));
        pick_o[1] = eligible_i[1] & (~eligible_i[0] | (lastGrant_i == REQ0));
    end

endmodule : rr_arbiter2

`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
//==============================================================================
// Module : regfile_write_arbiter
// Desc   : Arbitrates two write requesters onto one registerFile write port.
//          Define REGFILE_R0_PROTECT_EN to suppress writes to register 0.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [ADDR_WIDTH-1:0] reg0,
    input  logic [ADDR_WIDTH-1:0] reg1,
    input  logic [DATA_WIDTH-1:0] data0,
    input  logic [DATA_WIDTH-1:0] data1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  enable,
    output logic [ADDR_WIDTH-1:0] writeRegister,
    output logic [DATA_WIDTH-1:0] writeData,
    output logic                  lastGrant
);

    logic                  gnt0_q, gnt0_d;
    logic                  gnt1_q, gnt1_d;
    logic                  enable_q, enable_d;
    logic [ADDR_WIDTH-1:0] wreg_q, wreg_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    req_idx_t              last_q, last_d;

    logic [1:0]            eligible;
    logic [1:0]            pick;
    logic [ADDR_WIDTH-1:0] sel_reg;
    logic [DATA_WIDTH-1:0] sel_data;

    // A requester is ineligible during its own grant cycle, which forces the
    // one-write-per-two-cycles pacing for a single continuous requester.
    assign eligible = {req1 & ~gnt1_q, req0 & ~gnt0_q};

    rr_arbiter2 u_rr (
        .eligible_i  (eligible),
        .lastGrant_i (last_q),
        .pick_o      (pick)
    );

    assign sel_reg  = pick[1] ? reg1  : reg0;
    assign sel_data = pick[1] ? data1 : data0;

    always_comb begin
        gnt0_d  = pick[0];
        gnt1_d  = pick[1];
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        last_d  = last_q;
`ifdef REGFILE_R0_PROTECT_EN
        enable_d = (|pick) & (sel_reg != '0);
`else
        enable_d = |pick;
`endif
        if (|pick) begin
            wreg_d  = sel_reg;
            wdata_d = sel_data;
            last_d  = pick[1] ? REQ1 : REQ0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            enable_q <= 1'b0;
            wreg_q   <= '0;
            wdata_q  <= '0;
            last_q   <= REQ1;
        end else begin
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            enable_q <= enable_d;
            wreg_q   <= wreg_d;
            wdata_q  <= wdata_d;
            last_q   <= last_d;
        end
    end

    assign gnt0          = gnt0_q;
    assign gnt1          = gnt1_q;
    assign enable        = enable_q;
    assign writeRegister = wreg_q;
    assign writeData     = wdata_q;
    assign lastGrant     = last_q;

endmodule : regfile_write_arbiter

`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
//==============================================================================
// Module : tb_regfile_write_arbiter
// Desc   : Self-checking bench for regfile_write_arbiter with a registerFile
//          model and a rule-level reference model.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_regfile_write_arbiter;

    localparam int AW = 3;
    localparam int DW = 8;
    localparam int NR = 1 << AW;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic [AW-1:0] reg0 = '0, reg1 = '0;
    logic [DW-1:0] data0 = '0, data1 = '0;
    logic          gnt0, gnt1, enable, lastGrant;
    logic [AW-1:0] writeRegister;
    logic [DW-1:0] writeData;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_write_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock         (clock),
        .reset         (reset),
        .req0          (req0),
        .req1          (req1),
        .reg0          (reg0),
        .reg1          (reg1),
        .data0         (data0),
        .data1         (data1),
        .gnt0          (gnt0),
        .gnt1          (gnt1),
        .enable        (enable),
        .writeRegister (writeRegister),
        .writeData     (writeData),
        .lastGrant     (lastGrant)
    );

    always #5 clock = ~clock;

    // registerFile driven by the DUT write port
    logic [DW-1:0] rf [NR];
    logic          rf_clr = 1'b1;
    always @(posedge clock) begin
        if (rf_clr) begin
            for (int i = 0; i < NR; i++) rf[i] <= '0;
        end else if (enable) begin
            rf[writeRegister] <= writeData;
        end
    end

    // reference model state
    logic          m_gnt0, m_gnt1, m_en, m_last;
    logic [AW-1:0] m_wr;
    logic [DW-1:0] m_wd;
    logic [DW-1:0] m_rf [NR];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_gnt0 = 0; m_gnt1 = 0; m_en = 0; m_wr = '0; m_wd = '0; m_last = 1;
    endtask

    // one rising edge of the reference behaviour, using pre-edge inputs
    task automatic model_edge();
        logic e0, e1, g0, g1;
        logic [AW-1:0] r;
        if (m_en) m_rf[m_wr] = m_wd;
        e0 = req0 && !m_gnt0;
        e1 = req1 && !m_gnt1;
        g0 = 0; g1 = 0;
        if (e0 && e1) begin
            if (m_last) g0 = 1; else g1 = 1;
        end else begin
            g0 = e0; g1 = e1;
        end
        m_gnt0 = g0; m_gnt1 = g1;
        m_en = g0 | g1;
        if (g0 | g1) begin
            r      = g1 ? reg1 : reg0;
            m_wr   = r;
            m_wd   = g1 ? data1 : data0;
            m_last = g1;
`ifdef REGFILE_R0_PROTECT_EN
            if (r == 0) m_en = 0;
`endif
        end
    endtask

    task automatic check_outputs(input string pfx);
        check({pfx, ".gnt0"},  gnt0,          m_gnt0);
        check({pfx, ".gnt1"},  gnt1,          m_gnt1);
        check({pfx, ".en"},    enable,        m_en);
        check({pfx, ".wreg"},  writeRegister, m_wr);
        check({pfx, ".wdata"}, writeData,     m_wd);
        check({pfx, ".last"},  lastGrant,     m_last);
    endtask

    task automatic cycle(input string pfx);
        @(posedge clock);
        model_edge();
        #1;
        check_outputs(pfx);
    endtask

    task automatic apply_reset();
        reset = 1;
        req0 = 0; req1 = 0;
        #1;
        model_reset();
        check_outputs("rst_async");
        repeat (2) @(posedge clock);
        #1 reset = 0;
    endtask

    int gcount;
    logic en_prev;
    logic [DW-1:0] rf6_before;

    initial begin
        for (int i = 0; i < NR; i++) m_rf[i] = '0;
        model_reset();
        @(posedge clock);
        #1;
        apply_reset();
        rf_clr = 0;

        // single request: one-edge latency, commit one edge later
        req0 = 1; reg0 = 2; data0 = 3;
        cycle("s1");
        check("s1.gnt0_hi", gnt0, 1);
        check("s1.wr2", {enable, writeRegister, writeData}, {1'b1, 3'd2, 8'd3});
        req0 = 0;
        cycle("s1b");
        check("s1.rf2", rf[2], 3);

        // both at once after reset: requester 0 first
        apply_reset();
        req0 = 1; reg0 = 7; data0 = 5;
        req1 = 1; reg1 = 4; data1 = 9;
        cycle("s2a");
        check("s2.first", {gnt0, gnt1, lastGrant}, 3'b100);
        req0 = 0;
        cycle("s2b");
        check("s2.second", {gnt0, gnt1, lastGrant}, 3'b011);
        req1 = 0;
        cycle("s2c");
        check("s2.idle_hold", {enable, writeRegister, writeData}, {1'b0, 3'd4, 8'd9});

        // same register, lastGrant=0: gnt1 then gnt0, 0xAA wins
        req0 = 1; reg0 = 1; data0 = 8'h11;
        cycle("s3pre");
        req0 = 0;
        cycle("s3pre2");
        req0 = 1; reg0 = 5; data0 = 8'hAA;
        req1 = 1; reg1 = 5; data1 = 8'h55;
        cycle("s3a");
        check("s3.g1first", {gnt0, gnt1}, 2'b01);
        req1 = 0;
        cycle("s3b");
        check("s3.g0second", {gnt0, gnt1}, 2'b10);
        req0 = 0;
        cycle("s3c");
        check("s3.rf5", rf[5], 8'hAA);

        // continuous single requester: alternate-cycle grants
        gcount = 0; en_prev = 0;
        req0 = 1; reg0 = 3; data0 = 8'h3C;
        for (int i = 0; i < 6; i++) begin
            cycle("s4");
            if (gnt0) gcount++;
            check("s4.no_b2b", en_prev & enable, 0);
            en_prev = enable;
        end
        req0 = 0;
        check("s4.count", gcount, 3);
        cycle("s4end");

        // reset during a gnt1 cycle cancels the write
        rf6_before = rf[6];
        check("s5.rf6_pre", rf6_before, 0);
        req1 = 1; reg1 = 6; data1 = 8'h77;
        cycle("s5a");
        check("s5.gnt1", gnt1, 1);
        apply_reset();
        check("s5.rf6", rf[6], 0);
        check("s5.last", lastGrant, 1);

        // register 0 protection
        req1 = 1; reg1 = 0; data1 = 8'hFF;
        cycle("s6a");
        check("s6.gnt1", gnt1, 1);
`ifdef REGFILE_R0_PROTECT_EN
        check("s6.en", enable, 0);
`else
        check("s6.en", enable, 1);
`endif
        req1 = 0;
        cycle("s6b");
`ifdef REGFILE_R0_PROTECT_EN
        check("s6.rf0", rf[0], 0);
`else
        check("s6.rf0", rf[0], 8'hFF);
`endif

        // randomized protocol-respecting traffic
        for (int i = 0; i < 400; i++) begin
            cycle("rnd");
            check("rnd.onehot", gnt0 & gnt1, 0);
            if (m_gnt0 || !req0) begin
                req0 = $urandom_range(0, 1);
                reg0 = AW'($urandom); data0 = DW'($urandom);
            end else if ($urandom_range(0, 7) == 0) begin
                req0 = 0;
            end
            if (m_gnt1 || !req1) begin
                req1 = $urandom_range(0, 1);
                reg1 = AW'($urandom); data1 = DW'($urandom);
            end else if ($urandom_range(0, 7) == 0) begin
                req1 = 0;
            end
            if (i == 200) begin
                apply_reset();
            end
        end
        req0 = 0; req1 = 0;
        cycle("drain1");
        cycle("drain2");
        for (int i = 0; i < NR; i++) check("rf_final", rf[i], m_rf[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_regfile_write_arbiter

`default_nettype wire
